gr_file: RTL and testbench
==========================

// Module: gr_file
// PURPOSE
//  - General register file of the multi-cycle CPU: the write-back consumer of the GR write-data select.
//  - Stores 32 x 32-bit GPRs. Provides two combinational read ports (rs, rt).
//  - Provides the multi-cycle A/B operand latches, a retired-write counter and a sticky illegal-write flag.
//  - Sits between the write-back data select (input side) and the ALU operand selects (output side).
// PARAMETERS
//  - DATA_W  32  register width
//  - ADDR_W  5   register address width (2**ADDR_W registers)
//  - CNT_W   16  width of the retired-write counter
// PORTS
//  - clk          in   1       system clock, rising edge
//  - rst          in   1       asynchronous reset, active-high
//  - GR_WE        in   1       write enable, sampled at the rising edge of clk
//  - GR_W_ADDR    in   ADDR_W  write register index
//  - GR_W_DATA    in   DATA_W  write data, from the write-back data select
//  - GR_W_SRC     in   3       write-back select code (0 Z, 1 DRr, 2 HI, 3 LO, 4 PC, 5 CLZ, 6 CP0, 7 NONE)
//  - GR_RS_ADDR   in   ADDR_W  rs read index
//  - GR_RT_ADDR   in   ADDR_W  rt read index
//  - A_LATCH      in   1       capture the rs read value into A_data
//  - B_LATCH      in   1       capture the rt read value into B_data
//  - RS_data      out  DATA_W  combinational rs read
//  - RT_data      out  DATA_W  combinational rt read
//  - A_data       out  DATA_W  registered operand A
//  - B_data       out  DATA_W  registered operand B
//  - WR_COUNT     out  CNT_W   number of retired writes
//  - ILLEGAL_WR   out  1       sticky flag: a write was attempted with GR_W_SRC = NONE
// BEHAVIOUR
//  - Reset: rst asserted asynchronously clears all registers, A_data, B_data, WR_COUNT and ILLEGAL_WR to 0.
//    - The clear applies immediately, including in the middle of a multi-cycle instruction.
//    - With rst high, every clock edge is ignored.
//  - Write: a write is valid when GR_WE=1, GR_W_ADDR!=0 and GR_W_SRC!=7.
//    - A valid write updates reg[GR_W_ADDR] at the rising edge.
//    - Write latency is 1 cycle: the new value is visible on RS_data/RT_data after that edge.
//  - Register $0:
//    - Reads of $0 always return 0.
//    - A write to $0 is dropped silently. It does not change WR_COUNT or ILLEGAL_WR.
//  - GR_W_SRC=7 with GR_WE=1 and GR_W_ADDR!=0:
//    - The write is suppressed.
//    - ILLEGAL_WR is set to 1 and stays at 1 until reset.
//    - WR_COUNT does not change.
//  - WR_COUNT:
//    - Increments by 1 on each valid write.
//    - Saturates at 2**CNT_W-1 and does not wrap.
//  - Read ports RS_data and RT_data: purely combinational from the stored array.
//    - A write in the current cycle is not visible on them until after the edge.
//  - Operand latches:
//    - A_LATCH=1: A_data <= the rs read value at the rising edge. B_LATCH=1: B_data <= the rt read value.
//    - A latch whose enable is 0 holds its value.
//    - A_LATCH and B_LATCH are independent and may be asserted in the same cycle.
//  - A valid write and a latch of the same nonzero index in the same cycle: the latched value is set by GR_BYPASS_EN (see CONFIGURATION).
//  - The register array has no reset-free mode: all 32 entries are 0 after reset.
// CONFIGURATION
//  - GR_BYPASS_EN defined:
//    - A latch whose index equals a same-cycle valid write index captures GR_W_DATA (write-through).
//    - RS_data/RT_data stay unbypassed.
//  - GR_BYPASS_EN undefined: the latch captures the old stored value. The new value is seen one cycle later.
// TESTING
//  - Reset, then read all 32 indices -> every read is 0; WR_COUNT=0; ILLEGAL_WR=0.
//  - Write $5=0xDEADBEEF (SRC=0), next cycle RS_ADDR=5 -> RS_data=0xDEADBEEF; WR_COUNT=1.
//  - Write $0=0x1234 -> RS_data for index 0 is 0; WR_COUNT does not change.
//  - Write $7=0xAA (SRC=7) -> $7 stays 0; ILLEGAL_WR=1 and remains 1 after 10 idle cycles.
//  - Same cycle: write $3=0x55, A_LATCH with RS_ADDR=3, old $3=0x11:
//    - Macro defined -> A_data=0x55.
//    - Macro undefined -> A_data=0x11.
//  - CNT_W=4, 20 valid writes -> WR_COUNT=15.
//  - rst pulsed mid-sequence -> all outputs 0 immediately, with no clock edge.

Source files
------------

// File: rtl/gr_file.sv
// General register file of the multi-cycle CPU: 2**ADDR_W GPRs, two combinational
// read ports, A/B operand latches, retired-write counter, sticky illegal-write flag.
// Optional macro GR_BYPASS_EN: operand latches capture same-cycle write data.
module gr_file #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              GR_WE,
  input  logic [ADDR_W-1:0] GR_W_ADDR,
  input  logic [DATA_W-1:0] GR_W_DATA,
  input  logic [2:0]        GR_W_SRC,
  input  logic [ADDR_W-1:0] GR_RS_ADDR,
  input  logic [ADDR_W-1:0] GR_RT_ADDR,
  input  logic              A_LATCH,
  input  logic              B_LATCH,
  output logic [DATA_W-1:0] RS_data,
  output logic [DATA_W-1:0] RT_data,
  output logic [DATA_W-1:0] A_data,
  output logic [DATA_W-1:0] B_data,
  output logic [CNT_W-1:0]  WR_COUNT,
  output logic              ILLEGAL_WR
);

  localparam int          NUM_REGS = 1 << ADDR_W;
  localparam logic [2:0]  SRC_NONE = 3'd7;

  logic [DATA_W-1:0] regs [NUM_REGS];
  logic              wr_attempt;
  logic              wr_valid;
  logic              wr_illegal;
  logic [DATA_W-1:0] a_next;
  logic [DATA_W-1:0] b_next;

  // Writes to $0 are neither counted nor flagged, so the zero-index test gates both.
  assign wr_attempt = GR_WE && (GR_W_ADDR != '0);
  assign wr_valid   = wr_attempt && (GR_W_SRC != SRC_NONE);
  assign wr_illegal = wr_attempt && (GR_W_SRC == SRC_NONE);

  // NOTE: the array is reset explicitly, which forces flops instead of a RAM macro;
  // the CPU relies on every GPR reading 0 after reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else if (wr_valid) begin
      regs[GR_W_ADDR] <= GR_W_DATA;
    end
  end

  assign RS_data = (GR_RS_ADDR == '0) ? '0 : regs[GR_RS_ADDR];
  assign RT_data = (GR_RT_ADDR == '0) ? '0 : regs[GR_RT_ADDR];

  // NOTE: defaults first so every path assigns a_next/b_next and no latch is inferred.
  always_comb begin
    a_next = RS_data;
    b_next = RT_data;
`ifdef GR_BYPASS_EN
    if (wr_valid && (GR_W_ADDR == GR_RS_ADDR)) a_next = GR_W_DATA;
    if (wr_valid && (GR_W_ADDR == GR_RT_ADDR)) b_next = GR_W_DATA;
`endif
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      A_data     <= '0;
      B_data     <= '0;
      WR_COUNT   <= '0;
      ILLEGAL_WR <= 1'b0;
    end else begin
      if (A_LATCH) A_data <= a_next;
      if (B_LATCH) B_data <= b_next;
      if (wr_valid && (WR_COUNT != '1)) WR_COUNT <= WR_COUNT + CNT_W'(1);
      if (wr_illegal) ILLEGAL_WR <= 1'b1;
    end
  end

endmodule

// File: tb/tb_gr_file.sv
// Self-checking bench for gr_file: directed scenarios plus randomized traffic
// compared against an array-based model of the register file.
module tb_gr_file;

  logic        clk = 1'b0;
  logic        rst;
  logic        GR_WE;
  logic [4:0]  GR_W_ADDR;
  logic [31:0] GR_W_DATA;
  logic [2:0]  GR_W_SRC;
  logic [4:0]  GR_RS_ADDR;
  logic [4:0]  GR_RT_ADDR;
  logic        A_LATCH;
  logic        B_LATCH;
  logic [31:0] RS_data, RT_data, A_data, B_data;
  logic [15:0] WR_COUNT;
  logic        ILLEGAL_WR;
  logic [31:0] s_rs, s_rt, s_a, s_b;
  logic [3:0]  s_count;
  logic        s_illegal;

  int checks = 0;
  int errors = 0;

  // Model state
  logic [31:0] m_regs [32];
  int          m_count;
  int          m_count4;
  logic        m_illegal;
  logic [31:0] m_a, m_b;

  gr_file dut (
    .clk(clk), .rst(rst), .GR_WE(GR_WE), .GR_W_ADDR(GR_W_ADDR), .GR_W_DATA(GR_W_DATA),
    .GR_W_SRC(GR_W_SRC), .GR_RS_ADDR(GR_RS_ADDR), .GR_RT_ADDR(GR_RT_ADDR),
    .A_LATCH(A_LATCH), .B_LATCH(B_LATCH), .RS_data(RS_data), .RT_data(RT_data),
    .A_data(A_data), .B_data(B_data), .WR_COUNT(WR_COUNT), .ILLEGAL_WR(ILLEGAL_WR)
  );

  // Narrow-counter instance sharing the same stimulus, used for saturation.
  gr_file #(.CNT_W(4)) dut_sat (
    .clk(clk), .rst(rst), .GR_WE(GR_WE), .GR_W_ADDR(GR_W_ADDR), .GR_W_DATA(GR_W_DATA),
    .GR_W_SRC(GR_W_SRC), .GR_RS_ADDR(GR_RS_ADDR), .GR_RT_ADDR(GR_RT_ADDR),
    .A_LATCH(A_LATCH), .B_LATCH(B_LATCH), .RS_data(s_rs), .RT_data(s_rt),
    .A_data(s_a), .B_data(s_b), .WR_COUNT(s_count), .ILLEGAL_WR(s_illegal)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
    m_count = 0; m_count4 = 0; m_illegal = 1'b0; m_a = 32'h0; m_b = 32'h0;
  endtask

  task automatic idle_inputs();
    GR_WE = 1'b0; GR_W_ADDR = 5'd0; GR_W_DATA = 32'h0; GR_W_SRC = 3'd0;
    GR_RS_ADDR = 5'd0; GR_RT_ADDR = 5'd0; A_LATCH = 1'b0; B_LATCH = 1'b0;
  endtask

  // One clock: model computes the post-edge state from the current inputs, then
  // the bench waits for the edge and settles 1 ns past it.
  task automatic step();
    bit          do_write;
    logic [31:0] na, nb;
    do_write = GR_WE && GR_W_ADDR != 0 && GR_W_SRC != 3'd7;
    na = m_a; nb = m_b;
    if (!rst) begin
`ifdef GR_BYPASS_EN
      if (A_LATCH) na = (do_write && GR_W_ADDR == GR_RS_ADDR) ? GR_W_DATA : m_regs[GR_RS_ADDR];
      if (B_LATCH) nb = (do_write && GR_W_ADDR == GR_RT_ADDR) ? GR_W_DATA : m_regs[GR_RT_ADDR];
`else
      if (A_LATCH) na = m_regs[GR_RS_ADDR];
      if (B_LATCH) nb = m_regs[GR_RT_ADDR];
`endif
      if (do_write) begin
        m_regs[GR_W_ADDR] = GR_W_DATA;
        if (m_count < 65535) m_count++;
        if (m_count4 < 15) m_count4++;
      end
      if (GR_WE && GR_W_ADDR != 0 && GR_W_SRC == 3'd7) m_illegal = 1'b1;
      m_a = na; m_b = nb;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic write(input logic [4:0] addr, input logic [31:0] data, input logic [2:0] src);
    GR_WE = 1'b1; GR_W_ADDR = addr; GR_W_DATA = data; GR_W_SRC = src;
    step();
    GR_WE = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; idle_inputs(); model_reset();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 0; i < 32; i++) begin
      GR_RS_ADDR = 5'(i); GR_RT_ADDR = 5'(31 - i);
      #1;
      checks++;
      if (RS_data !== 32'h0 || RT_data !== 32'h0) begin
        errors++;
        $display("FAIL reset_read idx=%0d rs=%h rt=%h required 0", i, RS_data, RT_data);
      end
    end
    checks++;
    if (WR_COUNT !== 16'd0 || ILLEGAL_WR !== 1'b0 || A_data !== 0 || B_data !== 0) begin
      errors++;
      $display("FAIL reset_state count=%0d illegal=%b a=%h b=%h required 0", WR_COUNT, ILLEGAL_WR, A_data, B_data);
    end
  endtask

  task automatic test_write_read();
    write(5'd5, 32'hDEADBEEF, 3'd0);
    GR_RS_ADDR = 5'd5; GR_RT_ADDR = 5'd5;
    #1;
    checks++;
    if (RS_data !== 32'hDEADBEEF || RT_data !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL write_read rs=%h rt=%h required deadbeef", RS_data, RT_data);
    end
    checks++;
    if (WR_COUNT !== 16'd1) begin
      errors++;
      $display("FAIL write_count got=%0d required 1", WR_COUNT);
    end
  endtask

  task automatic test_zero_write();
    write(5'd0, 32'h1234, 3'd1);
    GR_RS_ADDR = 5'd0;
    #1;
    checks++;
    if (RS_data !== 32'h0 || WR_COUNT !== 16'd1 || ILLEGAL_WR !== 1'b0) begin
      errors++;
      $display("FAIL zero_write rs=%h count=%0d illegal=%b required 0/1/0", RS_data, WR_COUNT, ILLEGAL_WR);
    end
    // SRC=NONE to $0 is also dropped silently
    write(5'd0, 32'h1234, 3'd7);
    checks++;
    if (ILLEGAL_WR !== 1'b0) begin
      errors++;
      $display("FAIL zero_none_write illegal=%b required 0", ILLEGAL_WR);
    end
  endtask

  task automatic test_illegal();
    write(5'd7, 32'hAA, 3'd7);
    GR_RS_ADDR = 5'd7;
    #1;
    checks++;
    if (RS_data !== 32'h0 || ILLEGAL_WR !== 1'b1 || WR_COUNT !== 16'd1) begin
      errors++;
      $display("FAIL illegal_write rs=%h illegal=%b count=%0d required 0/1/1", RS_data, ILLEGAL_WR, WR_COUNT);
    end
    repeat (10) step();
    checks++;
    if (ILLEGAL_WR !== 1'b1) begin
      errors++;
      $display("FAIL illegal_sticky got=%b required 1", ILLEGAL_WR);
    end
  endtask

  task automatic test_latch_bypass();
    logic [31:0] exp_same;
`ifdef GR_BYPASS_EN
    exp_same = 32'h55;
`else
    exp_same = 32'h11;
`endif
    write(5'd3, 32'h11, 3'd0);
    GR_RS_ADDR = 5'd3; GR_RT_ADDR = 5'd3; A_LATCH = 1'b1; B_LATCH = 1'b1;
    write(5'd3, 32'h55, 3'd3);
    A_LATCH = 1'b0; B_LATCH = 1'b0;
    checks++;
    if (A_data !== exp_same || B_data !== exp_same) begin
      errors++;
      $display("FAIL latch_same_cycle a=%h b=%h required %h", A_data, B_data, exp_same);
    end
    checks++;
    if (RS_data !== 32'h55) begin
      errors++;
      $display("FAIL latch_rs_after rs=%h required 55", RS_data);
    end
    A_LATCH = 1'b1;
    step();
    A_LATCH = 1'b0;
    checks++;
    if (A_data !== 32'h55 || B_data !== exp_same) begin
      errors++;
      $display("FAIL latch_next_cycle a=%h b=%h required 55/%h", A_data, B_data, exp_same);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 300; n++) begin
      GR_WE = 1'($urandom_range(0, 3) != 0);
      GR_W_ADDR = 5'($urandom_range(0, 7));
      GR_W_DATA = $urandom;
      GR_W_SRC = 3'($urandom_range(0, 7));
      GR_RS_ADDR = 5'($urandom_range(0, 7));
      GR_RT_ADDR = 5'($urandom_range(0, 7));
      A_LATCH = 1'($urandom_range(0, 1));
      B_LATCH = 1'($urandom_range(0, 1));
      step();
      checks++;
      if (RS_data !== m_regs[GR_RS_ADDR] || RT_data !== m_regs[GR_RT_ADDR]) begin
        errors++;
        $display("FAIL rand_read n=%0d rs=%h/%h rt=%h/%h", n, RS_data, m_regs[GR_RS_ADDR], RT_data, m_regs[GR_RT_ADDR]);
      end
      checks++;
      if (A_data !== m_a || B_data !== m_b) begin
        errors++;
        $display("FAIL rand_latch n=%0d a=%h required %h b=%h required %h", n, A_data, m_a, B_data, m_b);
      end
      checks++;
      if (WR_COUNT !== 16'(m_count) || ILLEGAL_WR !== m_illegal || s_count !== 4'(m_count4)) begin
        errors++;
        $display("FAIL rand_status n=%0d count=%0d required %0d illegal=%b required %b", n, WR_COUNT, m_count, ILLEGAL_WR, m_illegal);
      end
    end
    idle_inputs();
  endtask

  task automatic test_saturation();
    #2 rst = 1'b1; model_reset();
    #1 rst = 1'b0;
    for (int i = 0; i < 20; i++) write(5'(1 + (i % 31)), 32'(i), 3'(i % 7));
    checks++;
    if (s_count !== 4'd15) begin
      errors++;
      $display("FAIL saturate_cnt4 got=%0d required 15", s_count);
    end
    checks++;
    if (WR_COUNT !== 16'd20) begin
      errors++;
      $display("FAIL count_cnt16 got=%0d required 20", WR_COUNT);
    end
  endtask

  task automatic test_async_reset();
    write(5'd9, 32'hCAFE0009, 3'd4);
    write(5'd4, 32'hAA, 3'd7);
    GR_RS_ADDR = 5'd9; GR_RT_ADDR = 5'd9; A_LATCH = 1'b1; B_LATCH = 1'b1;
    step();
    A_LATCH = 1'b0; B_LATCH = 1'b0;
    checks++;
    if (A_data !== 32'hCAFE0009 || ILLEGAL_WR !== 1'b1) begin
      errors++;
      $display("FAIL pre_reset a=%h illegal=%b required cafe0009/1", A_data, ILLEGAL_WR);
    end
    #2 rst = 1'b1;
    model_reset();
    #1;
    checks++;
    if (RS_data !== 0 || RT_data !== 0 || A_data !== 0 || B_data !== 0 || WR_COUNT !== 0 || ILLEGAL_WR !== 0) begin
      errors++;
      $display("FAIL async_reset rs=%h a=%h b=%h count=%0d illegal=%b required 0", RS_data, A_data, B_data, WR_COUNT, ILLEGAL_WR);
    end
    // Edges while held in reset must be ignored
    GR_WE = 1'b1; GR_W_ADDR = 5'd9; GR_W_DATA = 32'h77; GR_W_SRC = 3'd7; A_LATCH = 1'b1;
    step();
    checks++;
    if (RS_data !== 0 || A_data !== 0 || WR_COUNT !== 0 || ILLEGAL_WR !== 0) begin
      errors++;
      $display("FAIL reset_hold rs=%h a=%h count=%0d illegal=%b required 0", RS_data, A_data, WR_COUNT, ILLEGAL_WR);
    end
    idle_inputs();
    rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_zero_write();
    test_illegal();
    test_latch_bypass();
    test_random();
    test_saturation();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
